// File: rtl/pipe_elastic_stage_if.sv
// Valid/ready handshake bundle for the elastic stage.
// The slave side is the stage; the master side drives and consumes it.
interface pipe_elastic_stage_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] In;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] Out;
   logic             OutValid;
   logic             OutReady;

   modport master (
      output In, InValid, OutReady,
      input  InReady, Out, OutValid
   );

   modport slave (
      input  In, InValid, OutReady,
      output InReady, Out, OutValid
   );
endinterface

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: small FIFO with a registered head word,
// occupancy reporting and backpressure via InReady.
module pipe_elastic_stage #(
   parameter int WIDTH        = 16,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = 3
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         Flush,
   pipe_elastic_stage_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0]   Level,
   output logic                         AlmostFull,
   output logic                         Empty,
   output logic                         Full
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             afull_q, afull_d;
   logic             full, push, pop;

   assign full        = (level_q == LW'(DEPTH));
   assign bus.InReady = !full && !Rst && !Flush;
   assign push        = bus.InValid && bus.InReady;
   assign pop         = out_valid_q && bus.OutReady;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      out_d    = out_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.In;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      // Head register: refill from storage, or take In when it becomes head
      if (pop && (level_q > LW'(1))) begin
         out_d = mem_q[rd_ptr_q + 1'b1];
      end else if (push && ((level_q == '0) || pop)) begin
         out_d = bus.In;
      end
      if (Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         out_d    = '0;
      end
      out_valid_d = (level_d != '0);
      afull_d     = (level_d >= LW'(AFULL_THRESH));
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         afull_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         afull_q     <= afull_d;
      end
   end

   always_ff @(posedge Clk) begin
      mem_q <= mem_d;
   end

   assign bus.Out      = out_q;
   assign bus.OutValid = out_valid_q;
   assign Level        = level_q;
   assign AlmostFull   = afull_q;
   assign Empty        = (level_q == '0);
   assign Full         = full;
endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pipe_elastic_stage;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Flush;
   logic [2:0]  Level;
   logic        AlmostFull, Empty, Full;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] mq[$];
   logic [15:0] m_last;

   pipe_elastic_stage_if #(.WIDTH(16)) bus ();

   pipe_elastic_stage #(
      .WIDTH(16), .DEPTH(DEPTH), .AFULL_THRESH(AFT)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .bus(bus),
      .Level(Level), .AlmostFull(AlmostFull),
      .Empty(Empty), .Full(Full)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] e_out();
      return (mq.size() > 0) ? mq[0] : m_last;
   endfunction

   function automatic logic e_ready();
      return (mq.size() < DEPTH) && !Rst && !Flush;
   endfunction

   // One clock: drive inputs, advance model at the edge, settle at negedge
   task automatic tick(input logic iv, input logic [15:0] d,
                       input logic ordy, input logic fl, input logic rs);
      logic can_push;
      bus.InValid  = iv;
      bus.In       = d;
      bus.OutReady = ordy;
      Flush        = fl;
      Rst          = rs;
      @(posedge Clk);
      if (rs || fl) begin
         mq.delete();
         m_last = '0;
      end else begin
         can_push = (mq.size() < DEPTH);
         if (mq.size() > 0 && ordy) m_last = mq.pop_front();
         if (iv && can_push) mq.push_back(d);
      end
      @(negedge Clk);
   endtask

   task automatic test_reset();
      tick(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.InReady !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_inready got=%b exp=0", bus.InReady);
      end
      Rst = 1'b0;
      bus.InValid = 1'b0;
      #1;
      vectors++;
      if (bus.OutValid !== 1'b0 || bus.Out !== 16'h0 || Level !== 3'd0 ||
          Empty !== 1'b1 || Full !== 1'b0 || AlmostFull !== 1'b0 ||
          bus.InReady !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state ov=%b out=%h lvl=%0d e=%b f=%b af=%b rdy=%b exp 0 0 0 1 0 0 1",
                  bus.OutValid, bus.Out, Level, Empty, Full, AlmostFull, bus.InReady);
      end
   endtask

   task automatic test_single();
      tick(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.OutValid !== 1'b1 || bus.Out !== 16'h1234 || Level !== 3'd1) begin
         miscompares++;
         $display("FAIL single_push ov=%b out=%h lvl=%0d exp 1 1234 1",
                  bus.OutValid, bus.Out, Level);
      end
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus.OutValid !== 1'b0 || bus.Out !== 16'h1234 || Level !== 3'd0 ||
          Empty !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pop ov=%b out=%h lvl=%0d e=%b exp 0 1234 0 1",
                  bus.OutValid, bus.Out, Level, Empty);
      end
   endtask

   task automatic test_fill();
      logic [15:0] exp_seq [4];
      logic [2:0]  exp_lvl [5];
      exp_seq = '{16'd2, 16'd3, 16'd4, 16'd5};
      exp_lvl = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      for (int i = 1; i <= 4; i++) begin
         tick(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
         vectors++;
         if (Level !== 3'(i) || AlmostFull !== (i >= AFT)) begin
            miscompares++;
            $display("FAIL fill_level i=%0d lvl=%0d af=%b exp lvl=%0d af=%b",
                     i, Level, AlmostFull, i, (i >= AFT));
         end
      end
      vectors++;
      if (Full !== 1'b1 || bus.InReady !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full full=%b rdy=%b exp 1 0", Full, bus.InReady);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (bus.Out !== 16'd1 || Level !== 3'd4 || bus.OutValid !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_hold out=%h lvl=%0d exp 0001 4", bus.Out, Level);
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick(i < 2, 16'd5, 1'b1, 1'b0, 1'b0);
         vectors++;
         if (Level !== exp_lvl[i] ||
             (i < 4 && (bus.Out !== exp_seq[i] || bus.OutValid !== 1'b1)) ||
             (i == 4 && (bus.OutValid !== 1'b0 || bus.Out !== 16'd5))) begin
            miscompares++;
            $display("FAIL drain c=%0d out=%h ov=%b lvl=%0d exp lvl=%0d",
                     i, bus.Out, bus.OutValid, Level, exp_lvl[i]);
         end
      end
   endtask

   task automatic test_simul();
      tick(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (Level !== 3'd2 || bus.Out !== 16'h0022) begin
         miscompares++;
         $display("FAIL simul_level lvl=%0d out=%h exp 2 0022", Level, bus.Out);
      end
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus.Out !== 16'hAAAA || Level !== 3'd1) begin
         miscompares++;
         $display("FAIL simul_order out=%h lvl=%0d exp aaaa 1", bus.Out, Level);
      end
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) tick(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
      tick(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
      Flush = 1'b0;
      bus.InValid = 1'b0;
      #1;
      vectors++;
      if (Level !== 3'd0 || bus.OutValid !== 1'b0 || bus.Out !== 16'h0 ||
          bus.InReady !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_state lvl=%0d ov=%b out=%h rdy=%b exp 0 0 0000 1",
                  Level, bus.OutValid, bus.Out, bus.InReady);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
         vectors++;
         if (bus.OutValid !== 1'b0 || bus.Out === 16'hBEEF) begin
            miscompares++;
            $display("FAIL flush_leak ov=%b out=%h exp ov=0", bus.OutValid, bus.Out);
         end
      end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 100; k++) begin
         tick(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
         vectors++;
         if (bus.Out !== 16'(k) || bus.OutValid !== 1'b1 || Level !== 3'd1 ||
             bus.InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL stream k=%0d out=%h ov=%b lvl=%0d rdy=%b exp %h 1 1 1",
                     k, bus.Out, bus.OutValid, Level, bus.InReady, 16'(k));
         end
      end
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus.OutValid !== 1'b0 || bus.Out !== 16'd99) begin
         miscompares++;
         $display("FAIL stream_end ov=%b out=%h exp 0 0063", bus.OutValid, bus.Out);
      end
   endtask

   task automatic test_random();
      logic iv, ordy, fl;
      for (int c = 0; c < 400; c++) begin
         iv   = 1'($urandom_range(0, 3) != 0);
         ordy = 1'($urandom_range(0, 1));
         fl   = 1'($urandom_range(0, 39) == 0);
         tick(iv, 16'($urandom), ordy, fl, 1'b0);
         vectors++;
         if (bus.Out !== e_out() || bus.OutValid !== (mq.size() > 0) ||
             Level !== 3'(mq.size()) || AlmostFull !== (mq.size() >= AFT) ||
             Empty !== (mq.size() == 0) || Full !== (mq.size() == DEPTH) ||
             bus.InReady !== e_ready()) begin
            miscompares++;
            $display("FAIL random c=%0d out=%h/%h ov=%b lvl=%0d/%0d af=%b e=%b f=%b rdy=%b/%b",
                     c, bus.Out, e_out(), bus.OutValid, Level, mq.size(),
                     AlmostFull, Empty, Full, bus.InReady, e_ready());
         end
      end
      for (int c = 0; c < DEPTH + 1; c++) tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (Level !== 3'd0 || bus.OutValid !== 1'b0 || bus.Out !== m_last) begin
         miscompares++;
         $display("FAIL random_drain lvl=%0d ov=%b out=%h exp 0 0 %h",
                  Level, bus.OutValid, bus.Out, m_last);
      end
   endtask

   initial begin
      Rst          = 1'b1;
      Flush        = 1'b0;
      bus.InValid  = 1'b0;
      bus.In       = '0;
      bus.OutReady = 1'b0;
      m_last       = '0;
      test_reset();
      test_single();
      test_fill();
      test_simul();
      test_flush();
      test_stream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
